// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   HOLD_*        : 3-bit hold levels driven onto hold_en_o
//   state_t       : controller states (RUN=0, PEND=1, HALT=2)
//   RESET_VECTOR  : reset value of the pending redirect address
package pipe_ctrl_pkg;

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_IF   = 3'd2;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] RESET_VECTOR = 32'h0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the pipeline stages and pipe_ctrl.
//   master : request side (execute stage, interrupt controller, bus, debugger)
//            drives the *_i signals, observes the *_o signals
//   slave  : pipe_ctrl side, consumes requests, drives PC/IF/ID controls
interface pipe_ctrl_if;

    logic        ex_jump_en_i;
    logic [31:0] ex_jump_addr_i;
    logic        ex_hold_i;
    logic        irq_jump_en_i;
    logic [31:0] irq_jump_addr_i;
    logic        irq_hold_i;
    logic        bus_stall_i;
    logic        jtag_halt_i;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  hold_en_o;
    logic        flush_o;
    logic        halted_o;
    logic        stall_timeout_o;

    modport master (
        output ex_jump_en_i, ex_jump_addr_i, ex_hold_i,
        output irq_jump_en_i, irq_jump_addr_i, irq_hold_i,
        output bus_stall_i, jtag_halt_i,
        input  jump_en_o, jump_addr_o, hold_en_o, flush_o,
        input  halted_o, stall_timeout_o
    );

    modport slave (
        input  ex_jump_en_i, ex_jump_addr_i, ex_hold_i,
        input  irq_jump_en_i, irq_jump_addr_i, irq_hold_i,
        input  bus_stall_i, jtag_halt_i,
        output jump_en_o, jump_addr_o, hold_en_o, flush_o,
        output halted_o, stall_timeout_o
    );

endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Bus-stall watchdog: counts consecutive stalled cycles and emits a single
// registered pulse when the count reaches STALL_TIMEOUT.
//   clk, rst          : core clock, async active-high reset
//   bus_stall_i       : bus not ready this cycle
//   stall_timeout_o   : one-cycle pulse, the cycle after the count hits the limit
module stall_watchdog #(
    parameter int STALL_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic bus_stall_i,
    output logic stall_timeout_o
);

    localparam int CW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT    = CW'(STALL_TIMEOUT);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(STALL_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Saturating at LIMIT means the LIMIT_M1 -> LIMIT step happens once per
    // stall episode, so the pulse cannot re-fire until the stall drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt             <= '0;
            stall_timeout_o <= 1'b0;
        end else begin
            stall_timeout_o <= bus_stall_i && (cnt == LIMIT_M1);
            if (!bus_stall_i)
                cnt <= '0;
            else if (cnt != LIMIT)
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates redirects (irq over ex) and
// stall sources, replays a redirect that arrived during a bus stall, and
// parks the core for the debugger.
//   clk, rst : core clock, async active-high reset
//   bus      : pipe_ctrl_if.slave (requests in; jump/hold/flush/halt/timeout out)
//
//   state | meaning
//   RUN   | normal flow; redirects execute immediately unless the bus stalls
//   PEND  | redirect captured during a bus stall, replayed when the stall drops
//   HALT  | core held for the debugger until jtag_halt_i falls
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    state_t      state;
    logic [31:0] pend_addr;
    logic        halted;
    logic        redirect;
    logic [31:0] target;

    assign redirect = bus.irq_jump_en_i | bus.ex_jump_en_i;
    assign target   = bus.irq_jump_en_i ? bus.irq_jump_addr_i : bus.ex_jump_addr_i;

    always_comb begin
        bus.jump_en_o   = 1'b0;
        bus.jump_addr_o = 32'h0;
        bus.flush_o     = 1'b0;
        bus.hold_en_o   = HOLD_NONE;
        case (state)
            RUN: begin
                if (redirect && !bus.bus_stall_i) begin
                    bus.jump_en_o   = 1'b1;
                    bus.jump_addr_o = target;
                    bus.flush_o     = 1'b1;
                end else if (redirect || bus.bus_stall_i || bus.ex_hold_i ||
                             bus.irq_hold_i || bus.jtag_halt_i) begin
                    bus.hold_en_o = HOLD_ID;
                end
            end
            PEND: begin
                if (bus.bus_stall_i) begin
                    bus.hold_en_o = HOLD_ID;
                end else begin
                    bus.jump_en_o   = 1'b1;
                    bus.jump_addr_o = pend_addr;
                    bus.flush_o     = 1'b1;
                end
            end
            HALT: bus.hold_en_o = HOLD_ID;
            default: ;
        endcase
    end

    // halted tracks "next state is HALT", so it rises on the first HALT cycle
    // and falls on the first cycle back in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pend_addr <= RESET_VECTOR;
            halted    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect && bus.bus_stall_i) begin
                        pend_addr <= target;
                        state     <= PEND;
                        halted    <= 1'b0;
                    end else if (bus.jtag_halt_i) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        halted <= 1'b0;
                    end
                end
                PEND: begin
                    if (bus.bus_stall_i) begin
                        if (bus.irq_jump_en_i)
                            pend_addr <= bus.irq_jump_addr_i;
                    end else begin
                        state  <= bus.jtag_halt_i ? HALT : RUN;
                        halted <= bus.jtag_halt_i;
                    end
                end
                HALT: begin
                    if (!bus.jtag_halt_i) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    assign bus.halted_o = halted;

    stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_stall_watchdog (
        .clk             (clk),
        .rst             (rst),
        .bus_stall_i     (bus.bus_stall_i),
        .stall_timeout_o (bus.stall_timeout_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pipe_ctrl_if bus();

    pipe_ctrl #(
        .STALL_TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.ex_jump_en_i    = 1'b0;
        bus.ex_jump_addr_i  = 32'h0;
        bus.ex_hold_i       = 1'b0;
        bus.irq_jump_en_i   = 1'b0;
        bus.irq_jump_addr_i = 32'h0;
        bus.irq_hold_i      = 1'b0;
        bus.bus_stall_i     = 1'b0;
        bus.jtag_halt_i     = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #3;
        checks++; if (bus.jump_en_o !== 1'b0) begin errors++; $display("FAIL reset_jump_en: got %b want 0", bus.jump_en_o); end
        checks++; if (bus.jump_addr_o !== 32'h0) begin errors++; $display("FAIL reset_jump_addr: got %h want 0", bus.jump_addr_o); end
        checks++; if (bus.hold_en_o !== 3'd0) begin errors++; $display("FAIL reset_hold: got %0d want 0", bus.hold_en_o); end
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", bus.flush_o); end
        checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", bus.halted_o); end
        checks++; if (bus.stall_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", bus.stall_timeout_o); end
        cyc();
        rst = 1'b0;
        cyc();
        // Enter PEND, then reset asynchronously in the middle of a cycle.
        bus.ex_jump_en_i   = 1'b1;
        bus.ex_jump_addr_i = 32'h300;
        bus.bus_stall_i    = 1'b1;
        #2;
        checks++; if (bus.hold_en_o !== 3'd3) begin errors++; $display("FAIL rst_pend_entry_hold: got %0d want 3", bus.hold_en_o); end
        cyc();
        bus.ex_jump_en_i = 1'b0;
        #3;
        rst = 1'b1;
        idle();
        #1;
        checks++; if (bus.jump_en_o !== 1'b0) begin errors++; $display("FAIL rst_mid_pend_jump_en: got %b want 0", bus.jump_en_o); end
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL rst_mid_pend_flush: got %b want 0", bus.flush_o); end
        checks++; if (bus.hold_en_o !== 3'd0) begin errors++; $display("FAIL rst_mid_pend_hold: got %0d want 0", bus.hold_en_o); end
        checks++; if (bus.jump_addr_o !== 32'h0) begin errors++; $display("FAIL rst_mid_pend_addr: got %h want 0", bus.jump_addr_o); end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++; if (bus.jump_en_o !== 1'b0) begin errors++; $display("FAIL rst_release_no_jump[%0d]: got %b want 0", i, bus.jump_en_o); end
            cyc();
        end
    endtask

    task automatic test_simultaneous();
        idle();
        bus.ex_jump_en_i    = 1'b1;
        bus.ex_jump_addr_i  = 32'h100;
        bus.irq_jump_en_i   = 1'b1;
        bus.irq_jump_addr_i = 32'h80;
        bus.ex_hold_i       = 1'b1;
        #2;
        checks++; if (bus.jump_en_o !== 1'b1) begin errors++; $display("FAIL simul_jump_en: got %b want 1", bus.jump_en_o); end
        checks++; if (bus.jump_addr_o !== 32'h80) begin errors++; $display("FAIL simul_jump_addr: got %h want 00000080", bus.jump_addr_o); end
        checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL simul_flush: got %b want 1", bus.flush_o); end
        checks++; if (bus.hold_en_o !== 3'd0) begin errors++; $display("FAIL simul_hold: got %0d want 0", bus.hold_en_o); end
        cyc();
        idle();
        bus.ex_jump_en_i   = 1'b1;
        bus.ex_jump_addr_i = 32'h124;
        #2;
        checks++; if (bus.jump_addr_o !== 32'h124) begin errors++; $display("FAIL ex_only_addr: got %h want 00000124", bus.jump_addr_o); end
        cyc();
        idle();
        bus.irq_hold_i = 1'b1;
        #2;
        checks++; if (bus.hold_en_o !== 3'd3) begin errors++; $display("FAIL irq_hold: got %0d want 3", bus.hold_en_o); end
        checks++; if (bus.jump_en_o !== 1'b0) begin errors++; $display("FAIL irq_hold_no_jump: got %b want 0", bus.jump_en_o); end
        cyc();
        idle();
        #2;
        checks++; if (bus.hold_en_o !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", bus.hold_en_o); end
        cyc();
    endtask

    // irq_cycle < 0 means no overwrite; otherwise an irq redirect arrives in
    // that stall cycle (and an ex redirect in the next, which must be ignored).
    task automatic test_stalled_redirect(input int irq_cycle, input logic [31:0] want);
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.bus_stall_i     = 1'b1;
            bus.ex_jump_en_i    = (i == 0) || (irq_cycle >= 0 && i == irq_cycle + 1);
            bus.ex_jump_addr_i  = (i == 0) ? 32'h200 : 32'h999;
            bus.irq_jump_en_i   = (i == irq_cycle);
            bus.irq_jump_addr_i = (i == irq_cycle) ? 32'h40 : 32'h0;
            #2;
            checks++; if (bus.hold_en_o !== 3'd3) begin errors++; $display("FAIL stall_redir_hold[%0d]: got %0d want 3", i, bus.hold_en_o); end
            checks++; if (bus.jump_en_o !== 1'b0 || bus.jump_addr_o !== 32'h0) begin errors++; $display("FAIL stall_redir_nojump[%0d]: got %b/%h want 0/0", i, bus.jump_en_o, bus.jump_addr_o); end
            cyc();
        end
        idle();
        #2;
        checks++; if (bus.jump_en_o !== 1'b1) begin errors++; $display("FAIL replay_jump_en: got %b want 1", bus.jump_en_o); end
        checks++; if (bus.jump_addr_o !== want) begin errors++; $display("FAIL replay_addr: got %h want %h", bus.jump_addr_o, want); end
        checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL replay_flush: got %b want 1", bus.flush_o); end
        cyc();
        #2;
        checks++; if (bus.jump_en_o !== 1'b0) begin errors++; $display("FAIL replay_once: got %b want 0", bus.jump_en_o); end
        cyc();
    endtask

    task automatic test_halt();
        idle();
        for (int i = 0; i < 5; i++) begin
            bus.jtag_halt_i  = 1'b1;
            bus.ex_jump_en_i = (i == 2);
            bus.ex_jump_addr_i = 32'h700;
            #2;
            checks++; if (bus.hold_en_o !== 3'd3) begin errors++; $display("FAIL halt_hold[%0d]: got %0d want 3", i, bus.hold_en_o); end
            checks++; if (bus.halted_o !== (i >= 1)) begin errors++; $display("FAIL halt_halted[%0d]: got %b want %b", i, bus.halted_o, (i >= 1)); end
            checks++; if (bus.jump_en_o !== 1'b0) begin errors++; $display("FAIL halt_no_jump[%0d]: got %b want 0", i, bus.jump_en_o); end
            cyc();
        end
        idle();
        #2;
        checks++; if (bus.halted_o !== 1'b1) begin errors++; $display("FAIL halt_release_cycle: got %b want 1", bus.halted_o); end
        cyc();
        #2;
        checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL halt_after_release: got %b want 0", bus.halted_o); end
        checks++; if (bus.hold_en_o !== 3'd0) begin errors++; $display("FAIL halt_after_hold: got %0d want 0", bus.hold_en_o); end
        cyc();
    endtask

    task automatic test_halt_in_pend();
        idle();
        bus.ex_jump_en_i   = 1'b1;
        bus.ex_jump_addr_i = 32'h500;
        bus.bus_stall_i    = 1'b1;
        #2;
        cyc();
        idle();
        bus.jtag_halt_i = 1'b1;
        #2;
        checks++; if (bus.jump_en_o !== 1'b1 || bus.jump_addr_o !== 32'h500) begin errors++; $display("FAIL pend_halt_jump: got %b/%h want 1/00000500", bus.jump_en_o, bus.jump_addr_o); end
        checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL pend_halt_not_yet: got %b want 0", bus.halted_o); end
        cyc();
        bus.irq_jump_en_i   = 1'b1;
        bus.irq_jump_addr_i = 32'h44;
        #2;
        checks++; if (bus.halted_o !== 1'b1) begin errors++; $display("FAIL pend_halt_halted: got %b want 1", bus.halted_o); end
        checks++; if (bus.jump_en_o !== 1'b0 || bus.hold_en_o !== 3'd3) begin errors++; $display("FAIL pend_halt_ignored: got %b/%0d want 0/3", bus.jump_en_o, bus.hold_en_o); end
        cyc();
        idle();
        cyc();
        #2;
        checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL pend_halt_exit: got %b want 0", bus.halted_o); end
        cyc();
    endtask

    task automatic test_watchdog();
        idle();
        for (int i = 0; i < 10; i++) begin
            bus.bus_stall_i = 1'b1;
            #2;
            checks++; if (bus.stall_timeout_o !== (i == 4)) begin errors++; $display("FAIL wd_long[%0d]: got %b want %b", i, bus.stall_timeout_o, (i == 4)); end
            cyc();
        end
        idle();
        #2;
        checks++; if (bus.stall_timeout_o !== 1'b0) begin errors++; $display("FAIL wd_long_drop: got %b want 0", bus.stall_timeout_o); end
        cyc();
        for (int i = 0; i < 9; i++) begin
            bus.bus_stall_i = (i != 3) && (i < 7);
            #2;
            checks++; if (bus.stall_timeout_o !== 1'b0) begin errors++; $display("FAIL wd_short[%0d]: got %b want 0", i, bus.stall_timeout_o); end
            cyc();
        end
        idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_simultaneous();
        test_stalled_redirect(-1, 32'h200);
        test_stalled_redirect(1, 32'h40);
        test_halt();
        test_halt_in_pend();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencing controller for the core front-end. Arbitrates redirect requests (execute-stage branch/jump, interrupt/trap entry) and stall sources (multi-cycle execute, interrupt controller, bus stall, JTAG halt). Drives the `jump_en_i`/`jump_addr_i`/`hold_en_i` inputs of `program_counter` and the flush/hold controls of the IF/ID stage registers. Also replays a redirect that arrives during a bus stall, and flags a stuck bus.

## Interface
- `STALL_TIMEOUT`, 255: number of consecutive bus-stall cycles before `stall_timeout_o` fires; legal range 2..65535.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ex_jump_en_i`  in  1  execute-stage redirect request.
- `ex_jump_addr_i`  in  32  execute-stage target.
- `ex_hold_i`  in  1  execute-stage multi-cycle stall request.
- `irq_jump_en_i`  in  1  interrupt/trap redirect request.
- `irq_jump_addr_i`  in  32  trap vector / return address.
- `irq_hold_i`  in  1  interrupt controller stall request.
- `bus_stall_i`  in  1  instruction/data bus not ready.
- `jtag_halt_i`  in  1  debugger halt request, level.
- `jump_en_o`  out  1  redirect to PC (combinational).
- `jump_addr_o`  out  32  redirect target, 0 when `jump_en_o`=0.
- `hold_en_o`  out  3  hold level, HOLD_NONE=0, HOLD_PC=1, HOLD_IF=2, HOLD_ID=3 (combinational).
- `flush_o`  out  1  kill IF/ID contents (combinational).
- `halted_o`  out  1  core halted for debugger (registered).
- `stall_timeout_o`  out  1  one-cycle bus-timeout pulse (registered).

## Operation
- States: RUN, PEND, HALT. Reset state RUN. `pend_addr` register resets to 0.
- Redirect arbitration: irq beats ex. The selected target is `irq_jump_addr_i` if `irq_jump_en_i`, else `ex_jump_addr_i`.
- RUN, with a redirect request and `bus_stall_i`=0:
  - `jump_en_o`=1, `jump_addr_o`=target, `flush_o`=1, `hold_en_o`=HOLD_NONE.
  - Hold requests in the same cycle are ignored.
- RUN, with a redirect request and `bus_stall_i`=1:
  - latch target into `pend_addr`, go to PEND.
  - `jump_en_o`=0, `hold_en_o`=HOLD_ID.
- RUN, with no redirect: `hold_en_o`=HOLD_ID if any of `bus_stall_i`, `ex_hold_i`, `irq_hold_i`, `jtag_halt_i` is 1, else HOLD_NONE.
- RUN, with `jtag_halt_i`=1:
  - next state is HALT, unless a PEND entry occurs in the same cycle.
  - A redirect executed in that same cycle still completes first.
- PEND:
  - While `bus_stall_i`=1: `hold_en_o`=HOLD_ID. An `irq_jump_en_i` overwrites `pend_addr`; `ex_jump_en_i` is ignored.
  - When `bus_stall_i`=0: `jump_en_o`=1, `jump_addr_o`=`pend_addr`, `flush_o`=1. Next state is HALT if `jtag_halt_i`, else RUN.
- HALT:
  - `hold_en_o`=HOLD_ID, redirects ignored, `halted_o`=1 from the cycle after entry.
  - When `jtag_halt_i`=0: go to RUN; `halted_o` drops the next cycle.
- Stall watchdog:
  - Counter width is `$clog2(STALL_TIMEOUT+1)`.
  - Increments each cycle `bus_stall_i`=1 and clears when it is 0. Saturates at STALL_TIMEOUT.
  - `stall_timeout_o`=1 for exactly one cycle, the cycle after the counter goes from STALL_TIMEOUT-1 to STALL_TIMEOUT.
  - Does not re-fire until the stall drops.

## Timing
- Redirect latency: request at cycle N gives `jump_en_o` at cycle N, and the PC holds the target after edge N+1.
- PEND replay: `jump_en_o` in the first cycle `bus_stall_i`=0.
- Reset values: every output 0 and the counter 0 while `rst`=1 with inputs idle. State RUN, `halted_o`=0, `stall_timeout_o`=0.
- `rst` mid-PEND or mid-HALT: immediate return to RUN; the pending redirect is discarded.

## Structure
- `pipe_ctrl_pkg` holds:
  - HOLD_NONE/HOLD_PC/HOLD_IF/HOLD_ID localparams (3-bit).
  - the state encoding (RUN=0, PEND=1, HALT=2).
  - the reset-vector constant 32'h0.
- Sub-module `stall_watchdog` holds the counter and the pulse logic (params STALL_TIMEOUT; ports clk, rst, bus_stall_i, stall_timeout_o).
- The FSM, arbitration and the combinational output decode live in `pipe_ctrl`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle while in PEND, with all inputs idle. Expect all outputs 0 and a return to RUN; after release, no redirect occurs.
- Simultaneous redirects: `ex_jump_en_i`=1 (0x100) and `irq_jump_en_i`=1 (0x80) in one cycle, with `ex_hold_i`=1. Expect `jump_en_o`=1, `jump_addr_o`=0x80, `flush_o`=1, `hold_en_o`=0.
- Stalled redirect: `ex_jump_en_i` (0x200) with `bus_stall_i`=1 for 3 cycles, then 0.
  - Expect `hold_en_o`=3 for 3 cycles, then `jump_en_o`=1 with 0x200 in the release cycle.
  - Repeat with `irq_jump_en_i` (0x40) in stall cycle 2: expect 0x40.
- Debug halt: `jtag_halt_i`=1 for 5 cycles in RUN. Expect `hold_en_o`=3 from cycle 0 and `halted_o`=1 from cycle 1; `halted_o`=0 the cycle after release. Halt raised in PEND: expect the jump completes first, then HALT.
- Watchdog with STALL_TIMEOUT=4:
  - `bus_stall_i`=1 for 10 cycles: `stall_timeout_o` is high only in cycle 4.
  - Stall for 3 cycles, drop, stall for 3 cycles: no pulse.
